// File: rtl/idu_rf_prf.sv
// Physical register file: 64 x 64-bit data, per-preg ready bits and a busy count,
// written by four CDB ports and read by two zero-latency ports with CDB bypass.
module idu_rf_prf (
    input  logic        clk,
    input  logic        rst_clk,
    input  logic        rtu_global_flush,
    input  logic        exu_idu_rf_alu_cdb_vld,
    input  logic [5:0]  exu_idu_rf_alu_cdb_preg,
    input  logic [63:0] exu_idu_rf_alu_cdb_result,
    input  logic        exu_idu_rf_mxu_cdb_vld,
    input  logic [5:0]  exu_idu_rf_mxu_cdb_preg,
    input  logic [63:0] exu_idu_rf_mxu_cdb_result,
    input  logic        exu_idu_rf_div_cdb_vld,
    input  logic [5:0]  exu_idu_rf_div_cdb_preg,
    input  logic [63:0] exu_idu_rf_div_cdb_result,
    input  logic        exu_idu_rf_lsu_cdb_vld,
    input  logic [5:0]  exu_idu_rf_lsu_cdb_preg,
    input  logic [63:0] exu_idu_rf_lsu_cdb_result,
    input  logic        idu_rf_alloc_vld,
    input  logic [5:0]  idu_rf_alloc_preg,
    input  logic [5:0]  idu_rf_rd0_preg,
    input  logic [5:0]  idu_rf_rd1_preg,
    output logic [63:0] rf_idu_rd0_data,
    output logic [63:0] rf_idu_rd1_data,
    output logic        rf_idu_rd0_rdy,
    output logic        rf_idu_rd1_rdy,
    output logic [6:0]  rf_idu_busy_cnt
);

    // CDB ports indexed by priority: 0 = ALU (highest) .. 3 = LSU (lowest)
    logic [3:0]  cdb_vld;
    logic [5:0]  cdb_preg   [4];
    logic [63:0] cdb_result [4];
    logic [5:0]  rd_preg    [2];

    logic [63:0] data_reg [64];
    logic [63:0] wr_en;
    logic [63:0] wr_data  [64];
    logic [63:0] ready_reg, ready_next;
    logic [6:0]  busy_cnt_reg, busy_cnt_next;

    assign cdb_vld       = {exu_idu_rf_lsu_cdb_vld, exu_idu_rf_div_cdb_vld,
                            exu_idu_rf_mxu_cdb_vld, exu_idu_rf_alu_cdb_vld};
    assign cdb_preg[0]   = exu_idu_rf_alu_cdb_preg;
    assign cdb_preg[1]   = exu_idu_rf_mxu_cdb_preg;
    assign cdb_preg[2]   = exu_idu_rf_div_cdb_preg;
    assign cdb_preg[3]   = exu_idu_rf_lsu_cdb_preg;
    assign cdb_result[0] = exu_idu_rf_alu_cdb_result;
    assign cdb_result[1] = exu_idu_rf_mxu_cdb_result;
    assign cdb_result[2] = exu_idu_rf_div_cdb_result;
    assign cdb_result[3] = exu_idu_rf_lsu_cdb_result;
    assign rd_preg[0]    = idu_rf_rd0_preg;
    assign rd_preg[1]    = idu_rf_rd1_preg;

    // Scan lowest priority first so the highest-priority match overwrites.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
            for (int p = 3; p >= 0; p--) begin
                if (i != 0 && !rtu_global_flush && cdb_vld[p] && cdb_preg[p] == 6'(i)) begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = cdb_result[p];
                end
            end
        end
    end

    // Alloc is applied after the CDB so a same-cycle alloc leaves the preg not-ready.
    always_comb begin
        ready_next = ready_reg;
        if (rtu_global_flush) begin
            ready_next = '1;
        end else begin
            ready_next = ready_reg | wr_en;
            if (idu_rf_alloc_vld && idu_rf_alloc_preg != 6'd0)
                ready_next[idu_rf_alloc_preg] = 1'b0;
        end
        ready_next[0] = 1'b1;
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 1; i < 64; i++)
            busy_cnt_next = busy_cnt_next + 7'(!ready_next[i]);
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            ready_reg    <= '1;
            busy_cnt_reg <= '0;
        end else begin
            ready_reg    <= ready_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : gen_entry
            always_ff @(posedge clk or negedge rst_clk) begin
                if (!rst_clk)
                    data_reg[gi] <= '0;
                else if (wr_en[gi])
                    data_reg[gi] <= wr_data[gi];
            end
        end

        for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
            logic [63:0] data;
            logic        rdy;
            always_comb begin
                data = '0;
                rdy  = 1'b1;
                if (rd_preg[gi] != 6'd0) begin
                    data = data_reg[rd_preg[gi]];
                    rdy  = ready_reg[rd_preg[gi]];
                    if (!rtu_global_flush) begin
                        for (int p = 3; p >= 0; p--) begin
                            if (cdb_vld[p] && cdb_preg[p] == rd_preg[gi]) begin
                                data = cdb_result[p];
                                rdy  = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    assign rf_idu_rd0_data = gen_rd[0].data;
    assign rf_idu_rd0_rdy  = gen_rd[0].rdy;
    assign rf_idu_rd1_data = gen_rd[1].data;
    assign rf_idu_rd1_rdy  = gen_rd[1].rdy;
    assign rf_idu_busy_cnt = busy_cnt_reg;

endmodule

// File: tb/tb_idu_rf_prf.sv
// Directed bench for idu_rf_prf: expected read/busy values are queued as each step
// is driven and compared on the following falling edge.
module tb_idu_rf_prf;

    logic        clk;
    logic        rst_clk;
    logic        rtu_global_flush;
    logic        alu_vld, mxu_vld, div_vld, lsu_vld;
    logic [5:0]  alu_preg, mxu_preg, div_preg, lsu_preg;
    logic [63:0] alu_res, mxu_res, div_res, lsu_res;
    logic        alloc_vld;
    logic [5:0]  alloc_preg;
    logic [5:0]  rd0_preg, rd1_preg;
    logic [63:0] rd0_data, rd1_data;
    logic        rd0_rdy, rd1_rdy;
    logic [6:0]  busy_cnt;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       tag;
        logic [63:0] d0;
        logic        r0;
        logic [63:0] d1;
        logic        r1;
        logic [6:0]  busy;
    } exp_t;
    exp_t sb[$];

    idu_rf_prf dut (
        .clk                       (clk),
        .rst_clk                   (rst_clk),
        .rtu_global_flush          (rtu_global_flush),
        .exu_idu_rf_alu_cdb_vld    (alu_vld),
        .exu_idu_rf_alu_cdb_preg   (alu_preg),
        .exu_idu_rf_alu_cdb_result (alu_res),
        .exu_idu_rf_mxu_cdb_vld    (mxu_vld),
        .exu_idu_rf_mxu_cdb_preg   (mxu_preg),
        .exu_idu_rf_mxu_cdb_result (mxu_res),
        .exu_idu_rf_div_cdb_vld    (div_vld),
        .exu_idu_rf_div_cdb_preg   (div_preg),
        .exu_idu_rf_div_cdb_result (div_res),
        .exu_idu_rf_lsu_cdb_vld    (lsu_vld),
        .exu_idu_rf_lsu_cdb_preg   (lsu_preg),
        .exu_idu_rf_lsu_cdb_result (lsu_res),
        .idu_rf_alloc_vld          (alloc_vld),
        .idu_rf_alloc_preg         (alloc_preg),
        .idu_rf_rd0_preg           (rd0_preg),
        .idu_rf_rd1_preg           (rd1_preg),
        .rf_idu_rd0_data           (rd0_data),
        .rf_idu_rd1_data           (rd1_data),
        .rf_idu_rd0_rdy            (rd0_rdy),
        .rf_idu_rd1_rdy            (rd1_rdy),
        .rf_idu_busy_cnt           (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rtu_global_flush = 1'b0;
        alu_vld = 1'b0; mxu_vld = 1'b0; div_vld = 1'b0; lsu_vld = 1'b0;
        alu_preg = '0;  mxu_preg = '0;  div_preg = '0;  lsu_preg = '0;
        alu_res = '0;   mxu_res = '0;   div_res = '0;   lsu_res = '0;
        alloc_vld = 1'b0; alloc_preg = '0;
        rd0_preg = '0;  rd1_preg = '0;
    endtask

    // Queue the expectation for the cycle just driven, compare at the falling edge,
    // then advance past the rising edge and return with inputs idle.
    task automatic step(input string tag, input logic [63:0] d0, input logic r0,
                        input logic [63:0] d1, input logic r1, input logic [6:0] busy);
        exp_t e;
        e.tag = tag; e.d0 = d0; e.r0 = r0; e.d1 = d1; e.r1 = r1; e.busy = busy;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks += 5;
        assert (rd0_data === e.d0) else begin
            fails++; $error("FAIL %s rd0_data observed=%h expected=%h", e.tag, rd0_data, e.d0);
        end
        assert (rd0_rdy === e.r0) else begin
            fails++; $error("FAIL %s rd0_rdy observed=%b expected=%b", e.tag, rd0_rdy, e.r0);
        end
        assert (rd1_data === e.d1) else begin
            fails++; $error("FAIL %s rd1_data observed=%h expected=%h", e.tag, rd1_data, e.d1);
        end
        assert (rd1_rdy === e.r1) else begin
            fails++; $error("FAIL %s rd1_rdy observed=%b expected=%b", e.tag, rd1_rdy, e.r1);
        end
        assert (busy_cnt === e.busy) else begin
            fails++; $error("FAIL %s busy_cnt observed=%0d expected=%0d", e.tag, busy_cnt, e.busy);
        end
        $display("step %-14s rd0=%h/%b rd1=%h/%b busy=%0d", e.tag, rd0_data, rd0_rdy,
                 rd1_data, rd1_rdy, busy_cnt);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_clk = 1'b0;
        idle();
        rd0_preg = 6'd5;
        step("reset_hold", 64'h0, 1'b1, 64'h0, 1'b1, 7'd0);
        rd0_preg = 6'd5;
        #2 rst_clk = 1'b1;
        step("after_reset", 64'h0, 1'b1, 64'h0, 1'b1, 7'd0);

        alloc_vld = 1'b1; alloc_preg = 6'd5; rd0_preg = 6'd5;
        step("alloc5", 64'h0, 1'b1, 64'h0, 1'b1, 7'd0);
        rd0_preg = 6'd5;
        step("alloc5_rd", 64'h0, 1'b0, 64'h0, 1'b1, 7'd1);
        alu_vld = 1'b1; alu_preg = 6'd5; alu_res = 64'hDEAD; rd0_preg = 6'd5; rd1_preg = 6'd5;
        step("alu5_bypass", 64'hDEAD, 1'b1, 64'hDEAD, 1'b1, 7'd1);
        rd0_preg = 6'd5;
        step("alu5_array", 64'hDEAD, 1'b1, 64'h0, 1'b1, 7'd0);

        alu_vld = 1'b1; alu_preg = 6'd9; alu_res = 64'h1;
        lsu_vld = 1'b1; lsu_preg = 6'd9; lsu_res = 64'h2; rd0_preg = 6'd9;
        step("alu_lsu9_byp", 64'h1, 1'b1, 64'h0, 1'b1, 7'd0);
        rd0_preg = 6'd9;
        step("alu_lsu9_arr", 64'h1, 1'b1, 64'h0, 1'b1, 7'd0);
        mxu_vld = 1'b1; mxu_preg = 6'd20; mxu_res = 64'hAA;
        div_vld = 1'b1; div_preg = 6'd20; div_res = 64'hBB; rd1_preg = 6'd20;
        step("mxu_div20_byp", 64'h0, 1'b1, 64'hAA, 1'b1, 7'd0);
        rd1_preg = 6'd20;
        step("mxu_div20_arr", 64'h0, 1'b1, 64'hAA, 1'b1, 7'd0);

        alloc_vld = 1'b1; alloc_preg = 6'd12;
        mxu_vld = 1'b1; mxu_preg = 6'd12; mxu_res = 64'h77; rd0_preg = 6'd12;
        step("alloc_mxu12", 64'h77, 1'b1, 64'h0, 1'b1, 7'd0);
        rd0_preg = 6'd12;
        step("alloc_mxu12_rd", 64'h77, 1'b0, 64'h0, 1'b1, 7'd1);

        alloc_vld = 1'b1; alloc_preg = 6'd3; rd0_preg = 6'd3;
        step("alloc3", 64'h0, 1'b1, 64'h0, 1'b1, 7'd1);
        alloc_vld = 1'b1; alloc_preg = 6'd4; rd0_preg = 6'd3;
        step("alloc4", 64'h0, 1'b0, 64'h0, 1'b1, 7'd2);
        alloc_vld = 1'b1; alloc_preg = 6'd7; rd0_preg = 6'd4;
        step("alloc7", 64'h0, 1'b0, 64'h0, 1'b1, 7'd3);
        alloc_vld = 1'b1; alloc_preg = 6'd3; rd0_preg = 6'd7;
        step("alloc3_again", 64'h0, 1'b0, 64'h0, 1'b1, 7'd4);
        rtu_global_flush = 1'b1;
        div_vld = 1'b1; div_preg = 6'd3; div_res = 64'h55; rd0_preg = 6'd3; rd1_preg = 6'd12;
        step("flush_div3", 64'h0, 1'b0, 64'h77, 1'b0, 7'd4);
        rd0_preg = 6'd3; rd1_preg = 6'd12;
        step("after_flush", 64'h0, 1'b1, 64'h77, 1'b1, 7'd0);

        alloc_vld = 1'b1; alloc_preg = 6'd30;
        alu_vld = 1'b1; alu_preg = 6'd0; alu_res = 64'hFF; rd0_preg = 6'd30;
        step("alloc30", 64'h0, 1'b1, 64'h0, 1'b1, 7'd0);
        alloc_vld = 1'b1; alloc_preg = 6'd0;
        alu_vld = 1'b1; alu_preg = 6'd0; alu_res = 64'hFF;
        step("preg0_writes", 64'h0, 1'b1, 64'h0, 1'b1, 7'd1);
        rd1_preg = 6'd30;
        step("preg0_after", 64'h0, 1'b1, 64'h0, 1'b0, 7'd1);

        rst_clk = 1'b0;
        #1;
        rd0_preg = 6'd5; rd1_preg = 6'd9;
        step("async_reset", 64'h0, 1'b1, 64'h0, 1'b1, 7'd0);
        rst_clk = 1'b1;
        rd0_preg = 6'd12;
        step("post_reset", 64'h0, 1'b1, 64'h0, 1'b1, 7'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/idu_rf_prf.md
IDU_RF_PRF -- requirements
Module: idu_rf_prf

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
clk  in  1  clock, all state on rising edge
rst_clk  in  1  reset, asynchronous, active-low
rtu_global_flush  in  1  pipeline flush
exu_idu_rf_alu_cdb_vld / _preg / _result  in  1/6/64  ALU CDB writeback
exu_idu_rf_mxu_cdb_vld / _preg / _result  in  1/6/64  MXU CDB writeback
exu_idu_rf_div_cdb_vld / _preg / _result  in  1/6/64  DIV CDB writeback
exu_idu_rf_lsu_cdb_vld / _preg / _result  in  1/6/64  LSU CDB writeback
idu_rf_alloc_vld  in  1  rename allocates a destination preg
idu_rf_alloc_preg  in  6  allocated preg
idu_rf_rd0_preg, idu_rf_rd1_preg  in  6 each  source read addresses
rf_idu_rd0_data, rf_idu_rd1_data  out  64 each  source operand data
rf_idu_rd0_rdy, rf_idu_rd1_rdy  out  1 each  operand ready
rf_idu_busy_cnt  out  7  registered count of not-ready pregs
REQ-002 Reset SHALL be rst_clk, asynchronous, active-low; the clock SHALL be clk.

Function
REQ-003 State SHALL consist of 64 x 64-bit data entries, a 64-bit ready vector, and a 7-bit busy counter.
REQ-004 Preg 0 SHALL be hardwired: reads return data 0 and rdy 1; CDB writes and allocs to preg 0 SHALL be ignored.
REQ-005 A CDB port with vld=1 and preg!=0 SHALL write result into data[preg] and set ready[preg]=1 at the next rising edge.
REQ-006 When several CDB ports target the same preg in one cycle, priority SHALL be ALU > MXU > DIV > LSU; only the winner's data is written.
REQ-007 An alloc with alloc_vld=1 and preg!=0 SHALL clear ready[preg] at the next edge; data is unchanged.
REQ-008 When an alloc and a CDB write target the same preg in one cycle, the CDB data SHALL be written and ready SHALL end at 0, so the alloc wins.
REQ-009 While rtu_global_flush=1, all CDB writes and allocs SHALL be ignored, the ready vector SHALL be set to all ones, and busy_cnt SHALL be set to 0 at the next edge.
REQ-010 Reads SHALL be combinational with zero latency. If preg=0, the port returns 0/1.
REQ-011 Otherwise, if a CDB port has vld=1 with a matching preg and flush=0, the read SHALL return the highest-priority matching result with rdy=1 (bypass).
REQ-012 Otherwise, the read SHALL return data[preg] and ready[preg].
REQ-013 Bypass SHALL be suppressed during flush; array contents and ready are returned instead.
REQ-014 busy_cnt SHALL equal the number of zero bits in the ready vector, updated in the same cycle as the vector; range 0..63, with preg 0 never counted.
REQ-015 An alloc to a preg that is already not-ready SHALL leave busy_cnt unchanged.
REQ-016 A CDB write to a preg that is already ready SHALL rewrite the data and SHALL leave busy_cnt unchanged.

Reset
REQ-017 While rst_clk=0, the block SHALL be held in reset: all data entries 0, all ready bits 1, and busy_cnt 0.
REQ-018 While rst_clk=0, read outputs SHALL reflect the reset state: data 0 and rdy 1 for any address with no CDB bypass.
REQ-019 Reset deassertion SHALL require no extra cycles; alloc, CDB and read operations are valid on the first edge after release.

Verification
REQ-020 Scenario: reset, then read preg 5 -> data 0, rdy 1, busy_cnt 0.
REQ-021 Scenario: alloc preg 5, next cycle read -> rdy 0, busy_cnt 1; then ALU CDB preg 5 result 0xDEAD -> same-cycle read returns 0xDEAD rdy 1 by bypass, next cycle from array, busy_cnt 0.
REQ-022 Scenario: ALU and LSU both write preg 9 in the same cycle, with 0x1 and 0x2 -> next-cycle read returns 0x1.
REQ-023 Scenario: alloc preg 12 and MXU write preg 12 = 0x77 in the same cycle -> data 0x77, rdy 0, busy_cnt incremented.
REQ-024 Scenario: alloc pregs 3, 4 and 7, then assert flush together with a DIV write to preg 3 -> ready all ones, busy_cnt 0, data[3] unchanged, and the read during flush shows no bypass.
REQ-025 Scenario: CDB write to preg 0 with 0xFF and alloc of preg 0 -> reads of preg 0 return 0, rdy 1, and busy_cnt is unchanged.
